spiking_neuron_2in: RTL and testbench

Two-input integrate-and-fire neuron for the spiking network fabric. It holds two programmable signed synaptic weights and a membrane potential. Each cycle it adds the weight of every asserted input spike line to the potential and emits a one-cycle output spike when the potential reaches threshold. Weights and potential are managed over a shared address/command bus that the controller broadcasts to all neurons.

---
 rtl/spiking_neuron_2in.sv | 90 +++++++++
 tb/tb_spiking_neuron_2in.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spiking_neuron_2in.sv
// Two-input integrate-and-fire neuron: two programmable signed weights,
// a saturating membrane potential and a registered one-cycle output spike.
// Configuration arrives on a shared address/command bus.
module spiking_neuron_2in #(
    parameter int unsigned NEURON_ID  = 1,
    parameter int unsigned SILENT     = 1,
    parameter int unsigned INT_WIDTH  = 4,
    parameter int unsigned CMD_WIDTH  = 4,
    parameter int unsigned ADDR_WIDTH = 4,
    localparam int unsigned FW        = 2 * INT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [CMD_WIDTH-1:0]  cmd,
    input  logic signed [FW-1:0]  cmd_arg,
    input  logic                  in1,
    input  logic                  in2,
    output logic                  out
);

    localparam int unsigned SW = FW + 2;

    localparam logic [CMD_WIDTH-1:0] CMD_W1    = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CMD_W2    = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] CMD_CLEAR = CMD_WIDTH'((2 ** CMD_WIDTH) - 3);

    localparam logic signed [FW-1:0] TH      = FW'(2 ** (INT_WIDTH - 1));
    localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (FW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = -SW'(2 ** (FW - 1));

    logic signed [FW-1:0] w1;
    logic signed [FW-1:0] w2;
    logic signed [FW-1:0] pot;

    logic                 sel_c;
    logic                 fire_c;
    logic signed [SW-1:0] contrib_c;
    logic signed [SW-1:0] base_c;
    logic signed [SW-1:0] sum_c;
    logic signed [FW-1:0] sat_c;
    logic signed [FW-1:0] w1_nxt_c;
    logic signed [FW-1:0] w2_nxt_c;
    logic signed [FW-1:0] pot_nxt_c;

    // Logging is a simulation concern only; no logic is generated here.
    if (SILENT == 0) begin : g_log
    end

    // Command decode, integration with saturation and next-state selection.
    always_comb begin
        sel_c     = (addr == ADDR_WIDTH'(NEURON_ID));
        fire_c    = (pot >= TH);
        contrib_c = '0;
        if (in1) contrib_c = contrib_c + SW'(w1);
        if (in2) contrib_c = contrib_c + SW'(w2);
        // A firing neuron restarts from zero but keeps this cycle's inputs.
        base_c    = fire_c ? '0 : SW'(pot);
        sum_c     = base_c + contrib_c;
        if (sum_c > SAT_MAX)      sat_c = FW'(SAT_MAX);
        else if (sum_c < SAT_MIN) sat_c = FW'(SAT_MIN);
        else                      sat_c = FW'(sum_c);

        w1_nxt_c  = w1;
        w2_nxt_c  = w2;
        pot_nxt_c = sat_c;
        if (sel_c) begin
            if (cmd == CMD_W1) w1_nxt_c = cmd_arg;
            if (cmd == CMD_W2) w2_nxt_c = cmd_arg;
            // Clear wins over integration: same-cycle spikes are dropped.
            if (cmd == CMD_CLEAR) pot_nxt_c = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w1  <= '0;
            w2  <= '0;
            pot <= '0;
            out <= 1'b0;
        end else begin
            w1  <= w1_nxt_c;
            w2  <= w2_nxt_c;
            pot <= pot_nxt_c;
            out <= fire_c;
        end
    end

endmodule

// File: tb/tb_spiking_neuron_2in.sv
// Directed bench for spiking_neuron_2in. The driver pushes the hand-computed
// value of out expected after each edge; the monitor pops and compares.
module tb_spiking_neuron_2in;

    localparam int unsigned FW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [3:0]           addr;
    logic [3:0]           cmd;
    logic signed [FW-1:0] cmd_arg;
    logic                 in1;
    logic                 in2;
    logic                 out;

    bit    care_q[$];
    logic  exp_q[$];
    string tag_q[$];

    int checks = 0;
    int errors = 0;

    spiking_neuron_2in #(
        .NEURON_ID (1),
        .SILENT    (1),
        .INT_WIDTH (4),
        .CMD_WIDTH (4),
        .ADDR_WIDTH(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .cmd    (cmd),
        .cmd_arg(cmd_arg),
        .in1    (in1),
        .in2    (in2),
        .out    (out)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per rising edge, sampled 1 time unit later.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            bit    c;
            logic  e;
            string t;
            c = care_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (c) begin
                checks++;
                if (out !== e) begin
                    errors++;
                    $display("FAIL %s: out=%b expected %b", t, out, e);
                end
            end
        end
    end

    // Apply one cycle of stimulus and queue the out value after that edge.
    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] c,
                        input logic signed [FW-1:0] arg, input logic i1,
                        input logic i2, input bit care, input logic e,
                        input string t);
        @(negedge clk);
        rst = r; addr = a; cmd = c; cmd_arg = arg; in1 = i1; in2 = i2;
        care_q.push_back(care);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic wr(input logic [3:0] c, input logic signed [FW-1:0] arg,
                      input logic e, input string t);
        step(1'b1, 4'd1, c, arg, 1'b0, 1'b0, 1'b1, e, t);
    endtask

    task automatic spk(input logic i1, input logic i2, input logic e, input string t);
        step(1'b1, 4'hF, 4'd0, 8'sd0, i1, i2, 1'b1, e, t);
    endtask

    task automatic idle(input logic e, input string t);
        step(1'b1, 4'hF, 4'd0, 8'sd0, 1'b0, 1'b0, 1'b1, e, t);
    endtask

    initial begin
        rst = 1'b0; addr = 4'hF; cmd = 4'd0; cmd_arg = '0; in1 = 1'b0; in2 = 1'b0;

        step(1'b0, 4'hF, 4'd0, 8'sd0, 1'b0, 1'b0, 1'b1, 1'b0, "reset_0");
        step(1'b0, 4'hF, 4'd0, 8'sd0, 1'b0, 1'b0, 1'b1, 1'b0, "reset_1");

        // Sequential spikes on two synapses accumulate to 14 and fire once.
        wr(4'd1, 8'sd7, 1'b0, "prog_w1");
        wr(4'd2, 8'sd7, 1'b0, "prog_w2");
        wr(4'd13, 8'sd0, 1'b0, "prog_clear");
        wr(4'd0, 8'sd0, 1'b0, "prog_nop");
        spk(1'b1, 1'b0, 1'b0, "seq_edgeN");
        spk(1'b0, 1'b1, 1'b0, "seq_edgeN1");
        idle(1'b1, "seq_fire");
        idle(1'b0, "seq_single_pulse");
        idle(1'b0, "seq_quiet");

        // Simultaneous spikes add in one cycle.
        spk(1'b1, 1'b1, 1'b0, "sim_edgeN");
        idle(1'b1, "sim_fire");
        idle(1'b0, "sim_single_pulse");

        // Sub-threshold potential holds with no leak.
        spk(1'b1, 1'b0, 1'b0, "hold_load7");
        for (int i = 0; i < 10; i++) idle(1'b0, $sformatf("hold_quiet_%0d", i));
        spk(1'b1, 1'b0, 1'b0, "hold_add7");
        idle(1'b1, "hold_fire_14");
        idle(1'b0, "hold_after");

        // Reset with pot=14 suppresses the pending spike and clears state.
        spk(1'b1, 1'b1, 1'b0, "rst_load14");
        step(1'b0, 4'hF, 4'd0, 8'sd0, 1'b0, 1'b0, 1'b1, 1'b0, "rst_no_spike");
        idle(1'b0, "rst_quiet");

        // Commands to another neuron or to the idle address are ignored.
        step(1'b1, 4'd2, 4'd1, 8'sd7, 1'b0, 1'b0, 1'b1, 1'b0, "addr2_cmd");
        step(1'b1, 4'hF, 4'd1, 8'sd7, 1'b0, 1'b0, 1'b1, 1'b0, "addr_idle_cmd");
        spk(1'b1, 1'b0, 1'b0, "foreign_in1_a");
        spk(1'b1, 1'b0, 1'b0, "foreign_in1_b");
        idle(1'b0, "foreign_w1_still0");
        idle(1'b0, "foreign_quiet");

        // After reset pot is 0 and w2 is 0: only two w1 pulses reach threshold.
        wr(4'd1, 8'sd7, 1'b0, "rst_prog_w1");
        spk(1'b1, 1'b0, 1'b0, "rst_pot7");
        idle(1'b0, "rst_pot_was_cleared");
        spk(1'b0, 1'b1, 1'b0, "rst_w2_zero");
        idle(1'b0, "rst_w2_zero_quiet");
        spk(1'b1, 1'b0, 1'b0, "rst_pot14");
        idle(1'b1, "rst_pot14_fire");
        idle(1'b0, "rst_pot14_after");

        // Clear in the same cycle as a spike discards that spike.
        wr(4'd2, 8'sd7, 1'b0, "clr_prog_w2");
        spk(1'b1, 1'b0, 1'b0, "clr_pot7");
        step(1'b1, 4'd1, 4'd13, 8'sd0, 1'b0, 1'b1, 1'b1, 1'b0, "clr_with_in2");
        idle(1'b0, "clr_no_spike");
        spk(1'b1, 1'b0, 1'b0, "clr_pot_now7");
        idle(1'b0, "clr_pot_was0");
        idle(1'b0, "clr_quiet");

        // Positive saturation: 127+127 clamps to 127 instead of wrapping to -2.
        wr(4'd13, 8'sd0, 1'b0, "sat_clear");
        wr(4'd1, 8'sd127, 1'b0, "sat_w1");
        wr(4'd2, 8'sd127, 1'b0, "sat_w2");
        spk(1'b1, 1'b1, 1'b0, "satp_edge1");
        spk(1'b1, 1'b1, 1'b1, "satp_fire");
        step(1'b1, 4'd1, 4'd13, 8'sd0, 1'b0, 1'b0, 1'b0, 1'b0, "satp_clear");
        idle(1'b0, "satp_cleared");

        // Negative saturation: -128-128 clamps to -128, then +127 gives -1.
        wr(4'd1, -8'sd128, 1'b0, "satn_w1");
        wr(4'd2, -8'sd128, 1'b0, "satn_w2");
        spk(1'b1, 1'b1, 1'b0, "satn_sum");
        wr(4'd1, 8'sd127, 1'b0, "satn_w1_pos");
        spk(1'b1, 1'b0, 1'b0, "satn_to_m1");
        idle(1'b0, "satn_no_wrap");
        spk(1'b1, 1'b0, 1'b0, "satn_to_126");
        idle(1'b1, "satn_fire");
        idle(1'b0, "satn_after");

        // Drain the scoreboard with a bounded wait.
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
            end
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
